dcache_rv32: RTL and testbench
==============================

# dcache_rv32

Parametrised direct-mapped data cache between the RV32 core's memory stage and the next-level memory bus. Read hits complete with no stall. Read misses refill a one-word line over a request/acknowledge bus while holding the core with `oStallD`. Writes are write-through with per-byte enables, replacing the earlier flat single-cycle scratch array.

## Interface
Parameters:
- `LINES`, 8: number of one-word lines; power of two, ≥2. `IDXW = $clog2(LINES)`.
- `TAGW`, `30-IDXW`: tag width; derived, not overridden.

Ports:
- `iCLK` in 1: sole clock, rising edge.
- `iRST` in 1: reset, asynchronous, active-high.
- `iMEM` in 1: core memory request.
- `iRW` in 1: 1 = read, 0 = write.
- `iMEMADDR` in 32: byte address. Bits [1:0] ignored, index = [IDXW+1:2], tag = [31:IDXW+2].
- `iWDATA` in 32: store data.
- `iBE` in 4: byte enables for writes; ignored on reads.
- `oRDATA` out 32: registered load data.
- `oStallD` out 1: combinational; core must hold all request inputs while high.
- `oBUSREQ` out 1: bus request.
- `oBUSWE` out 1: 1 = bus write.
- `oBUSADDR` out 32: word-aligned address (bits [1:0] = 0).
- `oBUSWDATA` out 32: bus write data.
- `oBUSBE` out 4: bus byte enables.
- `iBUSACK` in 1: one-cycle acknowledge.
- `iBUSRDATA` in 32: read data, valid with `iBUSACK`.

## Operation
- Storage: data array `LINES`×32, tag array `LINES`×`TAGW`, valid bit per line.
- Hit = `valid[idx]` and `tag[idx] == addr tag`, evaluated combinationally from current inputs.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - No `iMEM`: stay IDLE.
  - Read hit: `oRDATA <= data[idx]` at the edge; stay IDLE.
  - Read miss: go to REFILL; register `oBUSREQ=1`, `oBUSWE=0`, aligned address.
  - Write (hit or miss): go to WRITE; register `oBUSREQ=1`, `oBUSWE=1`, address, `iWDATA`, `iBE`.
- REFILL: hold bus outputs. On the edge with `iBUSACK`:
  - write `data[idx]=iBUSRDATA`, set the tag and valid bit;
  - `oRDATA <= iBUSRDATA`;
  - drop `oBUSREQ` and go to IDLE.
- WRITE: hold bus outputs. On the edge with `iBUSACK`:
  - if hit, merge the enabled bytes into `data[idx]`;
  - drop `oBUSREQ` and go to IDLE.
- `oStallD`:
  - IDLE: `iMEM & (~iRW | ~hit)`.
  - REFILL/WRITE: `~iBUSACK`.
  - The core advances on the edge where `oStallD=0`.
- `iBE=4'h0` write: still issued on the bus; the cache array is unchanged.
- If `iMEM` drops while in REFILL/WRITE, the bus transaction still completes and a refill still fills the line.

## Timing
- Reset values: state IDLE, all valid bits 0, `oRDATA=0`, `oBUSREQ=0`, `oBUSWE=0`, `oBUSADDR=0`, `oBUSWDATA=0`, `oBUSBE=0`. `oStallD` follows `iMEM` (everything misses).
- Reset mid-REFILL/WRITE: `oBUSREQ` drops immediately and no line is updated. Data/tag arrays are not cleared, only the valid bits.
- Read hit: 0 stall cycles; data appears on `oRDATA` the cycle after the request edge.
- Read miss / write: 1 cycle to issue plus bus wait W cycles; the total stall is W+1 cycles.
- Bus rule: `oBUSREQ` and the bus payload are stable from assertion until the ack edge. `oBUSREQ` is low for at least one cycle between transactions. An `iBUSACK` seen in IDLE is ignored.
- Back-to-back: a new request can be accepted in IDLE on the cycle after the ack edge.

## Configuration
- `DCACHE_WRITE_ALLOCATE_EN` defined: a write miss with `iBE=4'hF` also installs the line (data, tag, valid) on the ack edge. Partial-byte write misses never allocate.
- `DCACHE_WRITE_ALLOCATE_EN` undefined: a write miss never modifies the cache arrays.

## Test plan
- Reset then read 0x40 with bus ack after 3 cycles returning 0xDEADBEEF:
  - `oStallD` high 4 cycles, `oRDATA=0xDEADBEEF`;
  - a repeat read of 0x40 completes with no stall.
- Write 0x40, `iWDATA=0x11223344`, `iBE=4'b0101` (line holds 0xDEADBEEF): bus sees addr 0x40, BE 0x5; a following read hit returns 0xDE22BE44.
- Conflict miss (`LINES=8`): read 0x40, then 0x60 (same index, different tag), then 0x40. The third access misses and refills.
- Full-word write miss to 0x80, then read 0x80: with the macro the read hits; without it the read misses.
- Assert `iRST` during REFILL wait: `oBUSREQ` goes 0 asynchronously; a later read of the same address misses.
- Read with ack on the first wait cycle, followed immediately by a read hit: no bubble beyond the single-cycle minimum; data order is correct.

Source files
------------

// File: rtl/dcache_rv32.sv
// Direct-mapped write-through data cache, one-word lines, req/ack refill bus.
// Define DCACHE_WRITE_ALLOCATE_EN to let full-word write misses install the line.
module dcache_rv32 #(
   parameter  int LINES = 8,
   localparam int IDXW  = $clog2(LINES),
   localparam int TAGW  = 30 - IDXW
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iMEM,
   input  logic        iRW,
   input  logic [31:0] iMEMADDR,
   input  logic [31:0] iWDATA,
   input  logic [3:0]  iBE,
   output logic [31:0] oRDATA,
   output logic        oStallD,
   output logic        oBUSREQ,
   output logic        oBUSWE,
   output logic [31:0] oBUSADDR,
   output logic [31:0] oBUSWDATA,
   output logic [3:0]  oBUSBE,
   input  logic        iBUSACK,
   input  logic [31:0] iBUSRDATA
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE
   } state_t;

   state_t            r_state;
   logic [LINES-1:0]  r_valid;
   logic [31:0]       r_data [LINES];
   logic [TAGW-1:0]   r_tag  [LINES];

   logic [IDXW-1:0]   w_idx;
   logic [TAGW-1:0]   w_tag;
   logic              w_hit;
   logic [IDXW-1:0]   w_bidx;
   logic [TAGW-1:0]   w_btag;
   logic              w_bhit;
   logic              w_alloc;
   logic              w_fill;
   logic              w_merge;
   logic [31:0]       w_fdata;
   logic              w_unused;

   assign w_idx    = iMEMADDR[IDXW+1:2];
   assign w_tag    = iMEMADDR[31:IDXW+2];
   assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_unused = ^iMEMADDR[1:0];

   // In-flight transactions use the latched bus address, so the core may drop iMEM
   assign w_bidx = oBUSADDR[IDXW+1:2];
   assign w_btag = oBUSADDR[31:IDXW+2];
   assign w_bhit = r_valid[w_bidx] && (r_tag[w_bidx] == w_btag);

`ifdef DCACHE_WRITE_ALLOCATE_EN
   assign w_alloc = !w_bhit && (oBUSBE == 4'hF);
`else
   assign w_alloc = 1'b0;
`endif

   assign w_fill  = iBUSACK &&
                    ((r_state == S_REFILL) ||
                     ((r_state == S_WRITE) && w_alloc));
   assign w_merge = iBUSACK && (r_state == S_WRITE) && w_bhit;
   assign w_fdata = (r_state == S_REFILL) ? iBUSRDATA : oBUSWDATA;

   always_comb begin
      oStallD = 1'b0;
      unique case (r_state)
         S_IDLE:   oStallD = iMEM && (!iRW || !w_hit);
         S_REFILL: oStallD = !iBUSACK;
         S_WRITE:  oStallD = !iBUSACK;
         default:  oStallD = 1'b0;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state   <= S_IDLE;
         r_valid   <= '0;
         oRDATA    <= '0;
         oBUSREQ   <= 1'b0;
         oBUSWE    <= 1'b0;
         oBUSADDR  <= '0;
         oBUSWDATA <= '0;
         oBUSBE    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (iMEM) begin
                  if (iRW && w_hit) begin
                     oRDATA <= r_data[w_idx];
                  end else if (iRW) begin
                     r_state  <= S_REFILL;
                     oBUSREQ  <= 1'b1;
                     oBUSWE   <= 1'b0;
                     oBUSADDR <= {iMEMADDR[31:2], 2'b00};
                  end else begin
                     r_state   <= S_WRITE;
                     oBUSREQ   <= 1'b1;
                     oBUSWE    <= 1'b1;
                     oBUSADDR  <= {iMEMADDR[31:2], 2'b00};
                     oBUSWDATA <= iWDATA;
                     oBUSBE    <= iBE;
                  end
               end
            end
            S_REFILL: begin
               if (iBUSACK) begin
                  r_valid[w_bidx] <= 1'b1;
                  oRDATA          <= iBUSRDATA;
                  oBUSREQ         <= 1'b0;
                  r_state         <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (iBUSACK) begin
                  if (w_alloc) r_valid[w_bidx] <= 1'b1;
                  oBUSREQ <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Arrays are not reset; an async reset forces IDLE so no update can slip through
   always_ff @(posedge iCLK) begin
      if (w_fill) begin
         r_data[w_bidx] <= w_fdata;
         r_tag[w_bidx]  <= w_btag;
      end else if (w_merge) begin
         for (int b = 0; b < 4; b++) begin
            if (oBUSBE[b]) r_data[w_bidx][8*b +: 8] <= oBUSWDATA[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dcache_rv32.sv
// Directed bench for dcache_rv32 with a latency-programmable bus responder.
// Expected values are hand-computed; allocate checks follow DCACHE_WRITE_ALLOCATE_EN.
module tb_dcache_rv32;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iMEM;
   logic        iRW;
   logic [31:0] iMEMADDR;
   logic [31:0] iWDATA;
   logic [3:0]  iBE;
   logic [31:0] oRDATA;
   logic        oStallD;
   logic        oBUSREQ;
   logic        oBUSWE;
   logic [31:0] oBUSADDR;
   logic [31:0] oBUSWDATA;
   logic [3:0]  oBUSBE;
   logic        iBUSACK;
   logic [31:0] iBUSRDATA;

   int          total = 0;
   int          bad   = 0;
   int          lat   = 0;
   int          cnt   = 0;
   int          n_tx  = 0;
   int          st;
   int          tx0;
   logic [31:0] bus_rdata = '0;
   logic [31:0] last_addr = '0;
   logic [31:0] last_wd   = '0;
   logic [3:0]  last_be   = '0;
   logic        last_we   = 1'b0;

   dcache_rv32 #(.LINES(8)) dut (
      .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW),
      .iMEMADDR(iMEMADDR), .iWDATA(iWDATA), .iBE(iBE),
      .oRDATA(oRDATA), .oStallD(oStallD),
      .oBUSREQ(oBUSREQ), .oBUSWE(oBUSWE), .oBUSADDR(oBUSADDR),
      .oBUSWDATA(oBUSWDATA), .oBUSBE(oBUSBE),
      .iBUSACK(iBUSACK), .iBUSRDATA(iBUSRDATA)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Acks after lat request cycles with no ack; one-cycle pulse
   initial begin
      iBUSACK   = 1'b0;
      iBUSRDATA = '0;
      forever begin
         @(negedge iCLK);
         if (iBUSACK) begin
            iBUSACK = 1'b0;
            cnt     = 0;
         end else if (oBUSREQ) begin
            if (cnt == lat) begin
               iBUSACK   = 1'b1;
               iBUSRDATA = bus_rdata;
               last_addr = oBUSADDR;
               last_we   = oBUSWE;
               last_be   = oBUSBE;
               last_wd   = oBUSWDATA;
               n_tx++;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the completing edge
   task automatic access(input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int l, output int stalls);
      int guard;
      lat      = l;
      iMEM     = 1'b1;
      iRW      = rw;
      iMEMADDR = a;
      iWDATA   = wd;
      iBE      = be;
      stalls   = 0;
      guard    = 0;
      forever begin
         @(negedge iCLK);
         #1;
         if (!oStallD) break;
         stalls++;
         guard++;
         if (guard > 50) begin
            chk("access_timeout", 32'(guard), 32'd0);
            break;
         end
         @(posedge iCLK);
         #1;
      end
      @(posedge iCLK);
      #1;
      iMEM = 1'b0;
   endtask

   initial begin
      iRST     = 1'b1;
      iMEM     = 1'b0;
      iRW      = 1'b1;
      iMEMADDR = '0;
      iWDATA   = '0;
      iBE      = '0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_rdata", oRDATA, 32'h0);
      chk("rst_req", 32'(oBUSREQ), 32'h0);
      chk("rst_we", 32'(oBUSWE), 32'h0);
      chk("rst_addr", oBUSADDR, 32'h0);
      chk("rst_wdata", oBUSWDATA, 32'h0);
      chk("rst_be", 32'(oBUSBE), 32'h0);
      iMEM = 1'b1;
      #1;
      chk("rst_stall_mem", 32'(oStallD), 32'h1);
      iMEM = 1'b0;
      #1;
      chk("rst_stall_idle", 32'(oStallD), 32'h0);
      iRST = 1'b0;
      @(posedge iCLK);
      #1;

      bus_rdata = 32'hDEADBEEF;
      access(1'b1, 32'h40, '0, '0, 3, st);
      chk("miss_stall", 32'(st), 32'd4);
      chk("miss_data", oRDATA, 32'hDEADBEEF);
      chk("miss_addr", last_addr, 32'h40);
      chk("miss_we", 32'(last_we), 32'h0);
      chk("miss_req_drop", 32'(oBUSREQ), 32'h0);

      tx0 = n_tx;
      access(1'b1, 32'h40, '0, '0, 0, st);
      chk("hit_stall", 32'(st), 32'd0);
      chk("hit_data", oRDATA, 32'hDEADBEEF);
      chk("hit_no_bus", 32'(n_tx - tx0), 32'd0);

      access(1'b0, 32'h40, 32'h11223344, 4'b0101, 1, st);
      chk("wr_stall", 32'(st), 32'd2);
      chk("wr_addr", last_addr, 32'h40);
      chk("wr_be", 32'(last_be), 32'h5);
      chk("wr_we", 32'(last_we), 32'h1);
      chk("wr_wdata", last_wd, 32'h11223344);
      access(1'b1, 32'h40, '0, '0, 0, st);
      chk("merge_stall", 32'(st), 32'd0);
      chk("merge_data", oRDATA, 32'hDE22BE44);

      bus_rdata = 32'h60606060;
      access(1'b1, 32'h60, '0, '0, 0, st);
      chk("conf_stall1", 32'(st), 32'd1);
      chk("conf_data1", oRDATA, 32'h60606060);
      bus_rdata = 32'hA5A5A5A5;
      access(1'b1, 32'h40, '0, '0, 0, st);
      chk("conf_stall2", 32'(st), 32'd1);
      chk("conf_data2", oRDATA, 32'hA5A5A5A5);

      access(1'b0, 32'h80, 32'hCAFEF00D, 4'hF, 0, st);
      chk("wmiss_stall", 32'(st), 32'd1);
      bus_rdata = 32'h12345678;
      access(1'b1, 32'h80, '0, '0, 0, st);
`ifdef DCACHE_WRITE_ALLOCATE_EN
      chk("alloc_stall", 32'(st), 32'd0);
      chk("alloc_data", oRDATA, 32'hCAFEF00D);
`else
      chk("noalloc_stall", 32'(st), 32'd1);
      chk("noalloc_data", oRDATA, 32'h12345678);
`endif

      bus_rdata = 32'h0BADF00D;
      access(1'b1, 32'h44, '0, '0, 0, st);
      access(1'b0, 32'h44, 32'hFFFFFFFF, 4'h0, 0, st);
      chk("be0_bus_be", 32'(last_be), 32'h0);
      chk("be0_bus_we", 32'(last_we), 32'h1);
      access(1'b1, 32'h44, '0, '0, 0, st);
      chk("be0_stall", 32'(st), 32'd0);
      chk("be0_data", oRDATA, 32'h0BADF00D);

      bus_rdata = 32'h77777777;
      lat      = 5;
      iMEM     = 1'b1;
      iRW      = 1'b1;
      iMEMADDR = 32'h48;
      repeat (3) @(posedge iCLK);
      #1;
      chk("rstmid_req_on", 32'(oBUSREQ), 32'h1);
      iRST = 1'b1;
      #1;
      chk("rstmid_req_off", 32'(oBUSREQ), 32'h0);
      iMEM = 1'b0;
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      @(posedge iCLK);
      #1;
      bus_rdata = 32'h48484848;
      access(1'b1, 32'h48, '0, '0, 0, st);
      chk("rstmid_miss", 32'(st), 32'd1);
      chk("rstmid_data", oRDATA, 32'h48484848);
      bus_rdata = 32'h44444444;
      access(1'b1, 32'h44, '0, '0, 0, st);
      chk("rst_inval", 32'(st), 32'd1);

      bus_rdata = 32'h50505050;
      access(1'b1, 32'h50, '0, '0, 0, st);
      chk("b2b_stall1", 32'(st), 32'd1);
      chk("b2b_data1", oRDATA, 32'h50505050);
      access(1'b1, 32'h48, '0, '0, 0, st);
      chk("b2b_stall2", 32'(st), 32'd0);
      chk("b2b_data2", oRDATA, 32'h48484848);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
